// File: rtl/isqrt_seq.sv
// isqrt_seq: sequential integer square root, one root bit per clock,
// using restoring digit-by-digit extraction.
// Optional output 'exact' (perfect-square flag) is built when the macro
// ISQRT_SEQ_EXACT_EN is defined.
module isqrt_seq #(
    parameter int unsigned WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     din,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH/2-1:0]   root,
    output logic [WIDTH/2:0]     rem
`ifdef ISQRT_SEQ_EXACT_EN
    ,
    output logic                 exact
`endif
);

    localparam int unsigned HW = WIDTH / 2;
    localparam int unsigned RW = HW + 2;
    localparam int unsigned CW = (HW > 1) ? $clog2(HW) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_n;
    logic [WIDTH-1:0] opnd;
    logic [HW-1:0]    prt;
    logic [RW-1:0]    trem;
    logic [CW-1:0]    cnt;

    logic             load;
    logic             last;
    logic [RW-1:0]    trial;
    logic [RW-1:0]    cmp;
    logic             ge;
    logic [RW-1:0]    trem_n;
    logic [HW-1:0]    prt_n;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic; a request is only taken outside CALC
    always_comb begin
        state_n = state;
        load    = 1'b0;
        last    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_n = CALC;
                end
            end
            CALC: begin
                if (cnt == '0) begin
                    last    = 1'b1;
                    state_n = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    load    = 1'b1;
                    state_n = CALC;
                end else begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // One restoring step: bring down two operand bits, try subtracting 4r+1
    always_comb begin
        trial  = (trem << 2) | RW'(opnd[WIDTH-1 -: 2]);
        cmp    = {prt, 2'b01};
        ge     = (trial >= cmp);
        trem_n = ge ? (trial - cmp) : trial;
        prt_n  = HW'({prt, ge});
    end

    // Status flags track the state being entered so they are flop outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_n == CALC);
            done <= (state_n == DONE);
        end
    end

    // Iteration datapath: operand shifter, partial root, trial remainder, counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opnd <= '0;
            prt  <= '0;
            trem <= '0;
            cnt  <= '0;
        end else if (load) begin
            opnd <= din;
            prt  <= '0;
            trem <= '0;
            cnt  <= CW'(HW - 1);
        end else if (state == CALC) begin
            opnd <= opnd << 2;
            prt  <= prt_n;
            trem <= trem_n;
            cnt  <= cnt - CW'(1);
        end
    end

    // Result registers only update on the final step and hold otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            root <= '0;
            rem  <= '0;
        end else if (last) begin
            root <= prt_n;
            rem  <= trem_n[HW:0];
        end
    end

`ifdef ISQRT_SEQ_EXACT_EN
    // Perfect-square flag, registered alongside root/rem
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exact <= 1'b0;
        end else if (last) begin
            exact <= (trem_n[HW:0] == '0);
        end
    end
`endif

endmodule

// File: tb/tb_isqrt_seq.sv
// tb_isqrt_seq: directed + randomized checks of isqrt_seq (WIDTH=6)
// against a plain floor-sqrt reference.
module tb_isqrt_seq;

    localparam int unsigned W = 6;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] din;
    logic         busy;
    logic         done;
    logic [2:0]   root;
    logic [3:0]   rem;
`ifdef ISQRT_SEQ_EXACT_EN
    logic         exact;
`endif

    int total = 0;
    int bad   = 0;

    isqrt_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .din   (din),
        .busy  (busy),
        .done  (done),
        .root  (root),
        .rem   (rem)
`ifdef ISQRT_SEQ_EXACT_EN
        ,
        .exact (exact)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int isqrt_ref(input int d);
        int r;
        r = 0;
        while ((r + 1) * (r + 1) <= d) r++;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, expect done exactly 3 edges after capture, check result
    task automatic run_op(input int d);
        int n;
        int r;
        bit seen;
        logic [2:0] root_s;
        r = isqrt_ref(d);
        din   = W'(d);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("done_after_start", done, 0);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 10) begin
            din = W'($urandom_range(63));
            tick();
            n++;
            if (done) seen = 1'b1;
        end
        chk("latency", n, 3);
        chk("root", root, r);
        chk("rem", rem, d - r * r);
        chk("busy_in_done", busy, 0);
`ifdef ISQRT_SEQ_EXACT_EN
        chk("exact", exact, (d == r * r) ? 1 : 0);
`endif
        root_s = root;
        din = W'($urandom_range(63));
        tick();
        chk("done_one_cycle", done, 0);
        chk("root_hold_idle", root, root_s);
    endtask

    initial begin
        int cnt;
        int d;
        logic [2:0] cap_root;
        logic [3:0] cap_rem;

        rst   = 1'b1;
        start = 1'b0;
        din   = '0;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_root", root, 0);
        chk("rst_rem", rem, 0);
        rst = 1'b0;
        tick();

        // Directed corner values
        run_op(0);
        run_op(63);
        run_op(36);
        run_op(35);

        // Second start during CALC must be ignored
        din = 6'd48; start = 1'b1;
        tick();
        din = 6'd9;
        tick();
        start = 1'b0;
        cnt = 0; cap_root = '0; cap_rem = '0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done) begin
                cnt++;
                cap_root = root;
                cap_rem  = rem;
            end
        end
        chk("ignore_done_count", cnt, 1);
        chk("ignore_root", cap_root, 6);
        chk("ignore_rem", cap_rem, 12);

        // Asynchronous reset in the middle of CALC
        din = 6'd50; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_root", root, 0);
        chk("abort_rem", rem, 0);
        tick();
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done || busy) cnt++;
        end
        chk("abort_stays_idle", cnt, 0);
        run_op(50);

        // start held high: back-to-back results every 4 cycles
        din = 6'd24; start = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk("b2b_done", done, (k % 4 == 0) ? 1 : 0);
            chk("b2b_busy", busy, (k % 4 != 0) ? 1 : 0);
            if (k % 4 == 0) begin
                chk("b2b_root", root, 4);
                chk("b2b_rem", rem, 8);
            end
        end
        start = 1'b0;
        tick();
        tick();

        // Exhaustive sweep
        for (int v = 0; v < 64; v++) run_op(v);

        // Random requests with idle gaps of random length
        for (int i = 0; i < 20; i++) begin
            d = int'($urandom_range(63));
            run_op(d);
            for (int j = 0; j < int'($urandom_range(2)); j++) begin
                din = W'($urandom_range(63));
                tick();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
